fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-003 The block SHALL have port nRst, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have port en, input, 1: fetch enable.
REQ-005 The block SHALL have port stall, input, 1: consumer not ready; hold the presented instruction.
REQ-006 The block SHALL have port branch_taken, input, 1: redirect strobe, one cycle.
REQ-007 The block SHALL have port branch_target, input, 32: redirect address.
REQ-008 The block SHALL have port imem_req, output, 1: instruction memory read request.
REQ-009 The block SHALL have port imem_addr, output, 32: request address.
REQ-010 The block SHALL have port imem_ack, input, 1: read complete; imem_rdata valid this cycle.
REQ-011 The block SHALL have port imem_rdata, input, 32: returned instruction word.
REQ-012 The block SHALL have port instr, output, 32 (word_t): instruction presented to the control unit's instr input.
REQ-013 The block SHALL have port instr_valid, output, 1: instr is live.
REQ-014 The block SHALL have port pc, output, 32: address of the presented instr.

Function
REQ-015 The block SHALL implement the FSM states IDLE, FETCH and ISSUE.
REQ-016 IDLE: imem_req=0 and instr_valid=0; en=1 SHALL move the FSM to FETCH on the next cycle.
REQ-017 FETCH: imem_req=1 and imem_addr=fetch_pc; req and addr SHALL stay stable until imem_ack and SHALL never be withdrawn early.
REQ-018 FETCH with imem_ack=1 and no pending redirect: instr<=imem_rdata, pc<=fetch_pc and fetch_pc<=fetch_pc+4, with transition to ISSUE.
REQ-019 instr_valid SHALL be 1 exactly while in ISSUE; latency from ack to instr_valid SHALL be 1 cycle.
REQ-020 ISSUE with stall=1: instr, pc and instr_valid SHALL be held unchanged.
REQ-021 ISSUE with stall=0: the instruction is consumed; next state SHALL be FETCH if en=1, else IDLE.
REQ-022 imem_req SHALL be 0 for at least the one cycle after every ack.
REQ-023 fetch_pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 branch_target[1:0] SHALL be forced to 2'b00 on capture.
REQ-025 branch_taken in IDLE: fetch_pc<=target with no other effect.
REQ-026 branch_taken in ISSUE (stall ignored): instr_valid=0 next cycle, fetch_pc<=target, next state FETCH if en=1 else IDLE.
REQ-027 branch_taken in FETCH without ack: set the flush flag and store the target; when ack arrives the data SHALL be discarded, fetch_pc<=stored target and the FSM SHALL re-enter FETCH after the mandatory idle cycle.
REQ-028 branch_taken coincident with ack in FETCH: the data SHALL be discarded and the new target used, as in REQ-027.
REQ-029 A second branch_taken while flush is pending: the latest target SHALL win.
REQ-030 en=0 in FETCH: the outstanding request SHALL complete, its instruction SHALL issue, and the FSM SHALL then go to IDLE.

Reset
REQ-031 nRst=0 at a clock edge SHALL force: state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, pc=RESET_PC, instr=NOP (32'h0000_0013), instr_valid=0, flush flag clear.
REQ-032 Reset mid-FETCH SHALL abandon the request; an ack arriving in IDLE SHALL be ignored.

Structure
REQ-033 cpu_pkg SHALL hold word_t, the NOP_INSTR constant and fetch_state_t (IDLE, FETCH, ISSUE).
REQ-034 A sub-module pc_unit SHALL own fetch_pc, the +4 increment, redirect and the flush-target register; the FSM SHALL stay in fetch_unit.

Verification
REQ-035 Reset, en=1, memory acks 2 cycles after req with words 0x00500093 and 0x00A00113: instr_valid pulses present those words with pc=0x0 then 0x4.
REQ-036 stall=1 for 3 cycles in ISSUE: instr, pc and instr_valid are unchanged; no imem_req until stall=0.
REQ-037 branch_taken with target 0x103 while FETCH at 0x8 is awaiting ack: the ack data is discarded, the next imem_addr=0x100, and the next instr_valid shows pc=0x100.
REQ-038 RESET_PC=0xFFFF_FFFC: the first issue has pc=0xFFFF_FFFC and the next imem_addr=0x0.
REQ-039 nRst=0 while imem_req=1: the next cycle shows imem_req=0, instr=0x00000013 and instr_valid=0; a late ack produces no issue.
REQ-040 branch_taken coincident with ack at 0xC, target 0x40: no instr_valid for the 0xC word, and a one-cycle req gap precedes req at 0x40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Fetch address register: sequential increment, redirects and the pending flush target.
module pc_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  nRst,
  input  logic  i_in_fetch,
  input  logic  i_ack,
  input  logic  i_branch,
  input  word_t i_target,
  output word_t o_fetch_pc,
  output logic  o_flush
);

  word_t r_fetch_pc;
  word_t r_flush_tgt;
  logic  r_flush;
  word_t w_tgt;

  assign w_tgt      = align_word(i_target);
  assign o_fetch_pc = r_fetch_pc;
  assign o_flush    = r_flush;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_fetch_pc  <= RESET_PC;
      r_flush_tgt <= RESET_PC;
      r_flush     <= 1'b0;
    end else if (i_in_fetch) begin
      // The request address must not move while a read is outstanding, so a
      // redirect during FETCH is parked until the ack retires the request.
      if (i_ack) begin
        r_flush <= 1'b0;
        if (i_branch)     r_fetch_pc <= w_tgt;
        else if (r_flush) r_fetch_pc <= r_flush_tgt;
        else              r_fetch_pc <= r_fetch_pc + 32'd4;
      end else if (i_branch) begin
        r_flush     <= 1'b1;
        r_flush_tgt <= w_tgt;
      end
    end else if (i_branch) begin
      r_fetch_pc <= w_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests words from instruction memory and presents them to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output word_t       instr,
  output logic        instr_valid,
  output logic [31:0] pc
);

  fetch_state_t r_state;
  logic         r_req;
  word_t        r_instr;
  logic         r_valid;
  word_t        r_pc;
  word_t        w_fetch_pc;
  logic         w_flush;
  logic         w_in_fetch;

  assign w_in_fetch  = (r_state == FETCH);
  assign imem_req    = r_req;
  assign imem_addr   = w_fetch_pc;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;

  pc_unit #(.RESET_PC(RESET_PC)) u_pc_unit (
    .clk        (clk),
    .nRst       (nRst),
    .i_in_fetch (w_in_fetch),
    .i_ack      (imem_ack),
    .i_branch   (branch_taken),
    .i_target   (branch_target),
    .o_fetch_pc (w_fetch_pc),
    .o_flush    (w_flush)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
          end
        end
        FETCH: begin
          // Every ack leaves FETCH, which guarantees a request-free cycle after it.
          if (imem_ack) begin
            r_req <= 1'b0;
            if (branch_taken || w_flush) begin
              r_state <= IDLE;
            end else begin
              r_instr <= imem_rdata;
              r_pc    <= w_fetch_pc;
              r_valid <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (branch_taken || !stall) begin
            r_valid <= 1'b0;
            if (en) begin
              r_state <= FETCH;
              r_req   <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        nRst = 1'b0, en = 1'b0, stall = 1'b0, br = 1'b0, imem_ack = 1'b0;
  logic [31:0] tgt = '0, imem_rdata = '0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc;

  logic        nRst2 = 1'b0, en2 = 1'b0, stall2 = 1'b0, br2 = 1'b0, ack2 = 1'b0;
  logic [31:0] tgt2 = '0, rdata2 = '0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int checks = 0;
  int errors = 0;

  // Model state: where the next request must point, and any pending discard.
  logic [31:0] m_next = RPC;
  logic [31:0] m_ftgt = '0;
  bit          m_discard = 1'b0;
  int          age = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .nRst(nRst), .en(en), .stall(stall), .branch_taken(br), .branch_target(tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc)
  );

  fetch_unit #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .nRst(nRst2), .en(en2), .stall(stall2), .branch_taken(br2), .branch_target(tgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .instr(instr2), .instr_valid(valid2), .pc(pc2)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of dut with the model applied to the pre-edge view.
  task automatic step();
    logic        p_req, p_valid;
    logic [31:0] p_addr, p_instr, p_pc, t;
    p_req = imem_req; p_valid = instr_valid; p_addr = imem_addr; p_instr = instr; p_pc = pc;
    imem_rdata = imem_ack ? mem(imem_addr) : $urandom;
    t = {tgt[31:2], 2'b00};
    @(posedge clk); #1;
    if (!nRst) begin
      m_next = RPC; m_discard = 1'b0;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_pc", pc, RPC);
      chk("rst_addr", imem_addr, RPC);
    end else if (p_req) begin
      if (imem_ack) begin
        bit issue;
        issue = 1'b0;
        if (br) m_next = t;
        else if (m_discard) m_next = m_ftgt;
        else begin m_next = p_addr + 32'd4; issue = 1'b1; end
        m_discard = 1'b0;
        chk("ack_gap_req", imem_req, 0);
        chk("ack_valid", instr_valid, issue);
        if (issue) begin
          chk("issue_instr", instr, mem(p_addr));
          chk("issue_pc", pc, p_addr);
        end
      end else begin
        if (br) begin m_discard = 1'b1; m_ftgt = t; end
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, p_addr);
        chk("fetch_valid", instr_valid, 0);
      end
    end else if (p_valid) begin
      if (br) m_next = t;
      if (stall && !br) begin
        chk("stall_valid", instr_valid, 1);
        chk("stall_instr", instr, p_instr);
        chk("stall_pc", pc, p_pc);
        chk("stall_req", imem_req, 0);
      end else begin
        chk("consume_valid", instr_valid, 0);
        chk("consume_req", imem_req, en);
        if (en) chk("consume_addr", imem_addr, m_next);
      end
    end else begin
      if (br) m_next = t;
      chk("idle_valid", instr_valid, 0);
      chk("idle_req", imem_req, en);
      if (en) chk("idle_addr", imem_addr, m_next);
    end
    age = (nRst && imem_req) ? age + 1 : 0;
  endtask

  task automatic cyc(input bit e, input bit s, input bit b, input logic [31:0] tg, input bit a);
    en = e; stall = s; br = b; tgt = tg; imem_ack = a;
    step();
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    nRst = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !instr_valid; i++) cyc(1, 0, 0, 0, imem_req && age > 2);
    chk(tag, instr_valid, 1);
  endtask

  task automatic wait_req_at(input string tag, input logic [31:0] a);
    for (int i = 0; i < 60 && !(imem_req && age == 1 && imem_addr == a); i++)
      cyc(1, 0, 0, 0, imem_req && age > 2);
    chk(tag, imem_addr, a);
  endtask

  initial begin
    // Wrap-around reset vector on the second instance.
    @(posedge clk); #1;
    chk("w_rst_req", req2, 0);
    chk("w_rst_pc", pc2, RPC2);
    chk("w_rst_instr", instr2, NOP_INSTR);
    nRst2 = 1'b1; en2 = 1'b1;
    @(posedge clk); #1;
    chk("w_req", req2, 1);
    chk("w_addr", addr2, RPC2);
    ack2 = 1'b1; rdata2 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("w_valid", valid2, 1);
    chk("w_pc", pc2, RPC2);
    chk("w_instr", instr2, 32'hDEAD_BEEF);
    ack2 = 1'b0;
    @(posedge clk); #1;
    chk("w_next_req", req2, 1);
    chk("w_next_addr", addr2, 32'h0);
    en2 = 1'b0;

    // Two sequential fetches, stall hold, then redirect while 0x8 is outstanding.
    do_reset();
    wait_valid("first_issue");
    chk("first_pc", pc, 32'h0);
    chk("first_instr", instr, 32'h0050_0093);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    chk("stalled_pc", pc, 32'h0);
    cyc(1, 0, 0, 0, 0);
    wait_valid("second_issue");
    chk("second_pc", pc, 32'h4);
    chk("second_instr", instr, 32'h00A0_0113);
    wait_req_at("reach_8", 32'h8);
    cyc(1, 0, 1, 32'h103, 0);
    for (int i = 0; i < 20 && !(imem_req && age == 1); i++) cyc(1, 0, 0, 0, imem_req && age > 2);
    chk("redirect_addr", imem_addr, 32'h100);
    wait_valid("redirect_issue");
    chk("redirect_pc", pc, 32'h100);

    // Branch coincident with the ack at 0xC.
    do_reset();
    wait_req_at("reach_c", 32'hC);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h40, 1);
    chk("coinc_no_valid", instr_valid, 0);
    chk("coinc_gap", imem_req, 0);
    cyc(1, 0, 0, 0, 0);
    chk("coinc_req", imem_req, 1);
    chk("coinc_addr", imem_addr, 32'h40);

    // Reset while a request is outstanding, then a late ack.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    chk("pre_rst_req", imem_req, 1);
    nRst = 1'b0;
    cyc(1, 0, 0, 0, 0);
    nRst = 1'b1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("late_ack_valid", instr_valid, 0);

    // Randomized traffic.
    for (int seg = 0; seg < 6; seg++) begin
      int lat;
      lat = $urandom_range(0, 3);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        logic [31:0] rt;
        bit a;
        rt = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
        a = imem_req ? (age > lat) : (!instr_valid && ($urandom % 5 == 0));
        nRst = ($urandom % 250 != 0);
        cyc($urandom % 8 != 0, $urandom % 3 == 0, $urandom % 16 == 0, rt, a);
      end
      nRst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
